// File: rtl/benes_xbar_ctx_pkg.sv
// benes_xbar_ctx_pkg: shared defaults, size derivations, column wiring and lane/switch types for the Benes crossbar
package benes_xbar_ctx_pkg;
  localparam int PORTS_DEF = 32;
  localparam int DATA_W_DEF = 512;
  localparam int CTX_NUM_DEF = 4;
  function automatic int stages(int ports);
    return 2 * $clog2(ports) - 1;
  endfunction
  function automatic int ctx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int src_lane(int q, int s, int ports);
    int l, n, b, o;
    l = $clog2(ports);
    if (s >= 2 * l - 2) return q;
    n = s < l - 1 ? ports >> s : ports >> (2 * l - 3 - s);
    b = q - q % n;
    o = q % n;
    return s < l - 1 ? b + (o < n / 2 ? 2 * o : 2 * (o - n / 2) + 1)
                     : b + (o % 2 == 1 ? n / 2 + o / 2 : o / 2);
  endfunction
  typedef logic [DATA_W_DEF-1:0] lane_t;
  typedef lane_t lanes_t [PORTS_DEF];
  typedef logic [PORTS_DEF/2-1:0] sw_t;
endpackage

// File: rtl/benes_col.sv
// benes_col: one column of 2x2 switches followed by the fixed wiring into the next Benes column
module benes_col
  import benes_xbar_ctx_pkg::*;
#(
  parameter int PORTS = 8,
  parameter int DATA_W = 8,
  parameter int STAGE = 0
) (
  input  logic [DATA_W-1:0]  d  [PORTS],
  input  logic [PORTS/2-1:0] sw,
  output logic [DATA_W-1:0]  q  [PORTS]
);
  logic [DATA_W-1:0] x [PORTS];
  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    localparam int J = src_lane(p, STAGE, PORTS);
    assign x[p] = sw[p/2] ? d[p^1] : d[p];
    assign q[p] = x[J];
  end
endmodule

// File: rtl/benes_xbar_ctx.sv
// benes_xbar_ctx: pipelined Benes permutation network with per-beat switch contexts; BENES_XBAR_LANE_MASK_EN adds per-context output lane masks
module benes_xbar_ctx
  import benes_xbar_ctx_pkg::*;
#(
  parameter int PORTS = PORTS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTX_NUM = CTX_NUM_DEF,
  localparam int S = stages(PORTS),
  localparam int CTX_W = ctx_w(CTX_NUM),
  localparam int SW = $clog2(S),
`ifdef BENES_XBAR_LANE_MASK_EN
  localparam int CFG_W = PORTS
`else
  localparam int CFG_W = PORTS / 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [CTX_W-1:0]  i_ctx,
  input  logic [DATA_W-1:0] i_data [PORTS],
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data [PORTS],
  input  logic              cfg_we,
  input  logic [CTX_W-1:0]  cfg_ctx,
  input  logic [SW-1:0]     cfg_stage,
  input  logic [CFG_W-1:0]  cfg_bits
);
  localparam int H = PORTS / 2;
  localparam logic [SW-1:0] S_IDX = SW'(S);
  logic [H-1:0] tbl [CTX_NUM][S];
  logic [H-1:0] csw [S];
  logic [S-1:0] vld;
  logic [DATA_W-1:0] dat [S][PORTS];
  logic [DATA_W-1:0] cd [S][PORTS];
  logic [DATA_W-1:0] cq [S][PORTS];
  logic [PORTS-1:0] en;
  logic stall;
  assign stall = vld[S-1] && !o_ready;
  assign i_ready = !stall;
  assign o_valid = vld[S-1];
  assign o_data = dat[S-1];
  assign csw[0] = tbl[i_ctx][0];
  // context table: reset to identity, writes to out-of-range columns dropped
  always_ff @(posedge clk)
    if (rst) tbl <= '{default: '0};
    else if (cfg_we && cfg_stage < S_IDX) tbl[cfg_ctx][cfg_stage] <= cfg_bits[H-1:0];
  for (genvar s = 1; s < S; s++) begin : g_sw
    logic [H-1:0] ch [s];
    assign csw[s] = ch[s-1];
    // carry this column's snapshotted switch bits alongside the beat until it reaches the column
    always_ff @(posedge clk)
      if (rst) ch <= '{default: '0};
      else if (!stall) begin
        ch[0] <= tbl[i_ctx][s];
        for (int c = 1; c < s; c++) ch[c] <= ch[c-1];
      end
  end
`ifdef BENES_XBAR_LANE_MASK_EN
  logic [PORTS-1:0] msk [CTX_NUM];
  logic [PORTS-1:0] mk [S-1];
  assign en = mk[S-2];
  // lane masks live at column index S and ride with the beat to the final column
  always_ff @(posedge clk)
    if (rst) begin
      msk <= '{default: '1};
      mk <= '{default: '1};
    end else begin
      if (cfg_we && cfg_stage == S_IDX) msk[cfg_ctx] <= cfg_bits;
      if (!stall) begin
        mk[0] <= msk[i_ctx];
        for (int c = 1; c < S - 1; c++) mk[c] <= mk[c-1];
      end
    end
`else
  assign en = '1;
`endif
  for (genvar c = 0; c < S; c++) begin : g_col
    for (genvar p = 0; p < PORTS; p++) begin : g_d
      if (c == 0) begin : g_i
        assign cd[c][p] = i_data[p];
      end else begin : g_r
        assign cd[c][p] = dat[c-1][p];
      end
    end
    benes_col #(.PORTS(PORTS), .DATA_W(DATA_W), .STAGE(c)) u_col (
      .d(cd[c]),
      .sw(csw[c]),
      .q(cq[c])
    );
  end
  // data pipeline: one register per column, frozen as a whole while the output is stalled
  always_ff @(posedge clk)
    if (rst) begin
      vld <= '0;
      for (int c = 0; c < S; c++)
        for (int p = 0; p < PORTS; p++) dat[c][p] <= '0;
    end else if (!stall) begin
      vld <= {vld[S-2:0], i_valid};
      for (int c = 0; c < S - 1; c++) dat[c] <= cq[c];
      for (int p = 0; p < PORTS; p++) dat[S-1][p] <= en[p] ? cq[S-1][p] : '0;
    end
endmodule
